// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: RAW hazard detection, branch flush,
// multi-cycle data-memory wait states and saturating stall/flush statistics.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_WAIT_CYCLES = 4,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             fwd_en,
    input  logic             id_valid,
    input  logic [4:0]       id_src1,
    input  logic [4:0]       id_src2,
    input  logic             id_two_src,
    input  logic [4:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_read,
    input  logic [4:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             mem_req,
    input  logic             branch_taken,
    output logic             hold_pc_ifid,
    output logic             bubble_id,
    output logic             flush_ifid,
    output logic             mem_stall,
    output logic             mem_done,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    localparam logic [7:0] LastCnt = 8'(MEM_WAIT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             m1, m2, match_exe, match_mem, haz;
    logic             stall_raw, done_raw;

    always_comb begin
        m1        = (id_src1 != 5'd0);
        m2        = id_two_src && (id_src2 != 5'd0);
        match_exe = (m1 && (id_src1 == exe_dest)) || (m2 && (id_src2 == exe_dest));
        match_mem = (m1 && (id_src1 == mem_dest)) || (m2 && (id_src2 == mem_dest));
        if (fwd_en) begin
            // Forwarding covers everything except a load still in EXE.
            haz = id_valid && exe_wb_en && exe_mem_read && match_exe;
        end else begin
            haz = id_valid && ((exe_wb_en && match_exe) || (mem_wb_en && match_mem));
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_raw = 1'b0;
        done_raw  = 1'b0;
        unique case (state_q)
            StIdle: begin
                stall_raw = mem_req;
                if (mem_req) begin
                    state_d = StWait;
                    cnt_d   = 8'd1;
                end
            end
            StWait: begin
                stall_raw = 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone: begin
                // The pipeline advances this cycle, so a pending request waits for IDLE.
                done_raw = 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset gates every control output so a mid-access reset drops the freeze at once.
    always_comb begin
        mem_stall    = reset && stall_raw;
        mem_done     = reset && done_raw;
        hold_pc_ifid = reset && (stall_raw || (haz && !branch_taken));
        flush_ifid   = reset && branch_taken && !stall_raw;
        bubble_id    = reset && !stall_raw && (haz || branch_taken);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (hold_pc_ifid && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush_ifid && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EXE, MEM, WB).
- Detects RAW hazards between the instruction in ID and the instructions in EXE/MEM, and applies taken-branch flushes.
- Sequences multi-cycle data-memory accesses with a wait-state FSM.
- Drives the ID-stage freeze (bubble) input, the PC/IF-ID hold and the flush signals, and keeps saturating stall/flush statistics.

Parameters:
- MEM_WAIT_CYCLES, 4, number of cycles the whole pipeline freezes per MEM-stage access; legal range 2..255.
- CNT_W, 16, width of the statistics counters.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- fwd_en  in  1  1 = forwarding unit active, 0 = no forwarding.
- id_valid  in  1  ID holds a real instruction.
- id_src1  in  5  ID rs field.
- id_src2  in  5  ID rt field.
- id_two_src  in  1  ID instruction reads rt (R-type, store, branch).
- exe_dest  in  5  EXE destination register.
- exe_wb_en  in  1  EXE writeback enable.
- exe_mem_read  in  1  EXE instruction is a load.
- mem_dest  in  5  MEM destination register.
- mem_wb_en  in  1  MEM writeback enable.
- mem_req  in  1  MEM instruction performs a load or store.
- branch_taken  in  1  EXE resolved a taken branch.
- hold_pc_ifid  out  1  hold the PC and IF/ID registers.
- bubble_id  out  1  freeze input of ID; zeroes control bits into ID/EXE.
- flush_ifid  out  1  clear IF/ID to a NOP.
- mem_stall  out  1  freeze all pipeline registers.
- mem_done  out  1  single-cycle pulse: memory access completes this cycle.
- stall_count  out  CNT_W  saturating count of hold cycles.
- flush_count  out  CNT_W  saturating count of flush cycles.

Behaviour:
- Reset (reset==0 at a clock edge): FSM goes to IDLE, wait counter and both statistics counters go to 0.
- While reset is low, all single-bit outputs are forced to 0.

Hazard term (combinational):
- m1 = id_src1 != 0.
- m2 = id_two_src and id_src2 != 0.
- match(d) = (m1 and id_src1 == d) or (m2 and id_src2 == d).
- fwd_en=1: haz = id_valid and exe_wb_en and exe_mem_read and match(exe_dest). This is the load-use case only.
- fwd_en=0: haz = id_valid and ((exe_wb_en and match(exe_dest)) or (mem_wb_en and match(mem_dest))).
- Register 0 never creates a hazard.

Memory FSM (states IDLE, WAIT, DONE; 8-bit counter cnt):
- IDLE: mem_stall = mem_req. If mem_req, go to WAIT with cnt = 1.
- WAIT: mem_stall = 1. If cnt == MEM_WAIT_CYCLES-1, go to DONE; else cnt++.
- DONE: mem_stall = 0, mem_done = 1, go to IDLE unconditionally. mem_req is ignored in DONE because the pipeline advances out of this cycle.
- Result: mem_stall is high for exactly MEM_WAIT_CYCLES consecutive cycles, then mem_done pulses for 1 cycle.
- Back-to-back accesses give at least 1 non-stall cycle (DONE) between stall windows.

Output combination (priority: mem_stall > branch_taken > haz):
- hold_pc_ifid = mem_stall or (haz and not branch_taken).
- flush_ifid = branch_taken and not mem_stall. A flush is deferred while frozen because the branch stays in EXE.
- bubble_id = not mem_stall and (haz or branch_taken).
- When branch_taken and haz coincide: the flush wins, the PC is not held, and the wrong-path ID instruction is bubbled.

Statistics:
- stall_count increments on every cycle with hold_pc_ifid = 1.
- flush_count increments on every cycle with flush_ifid = 1.
- Both saturate at all-ones and never wrap.

Reset mid-access:
- The FSM aborts to IDLE and mem_stall drops immediately.
- A mem_req still high after reset releases starts a fresh full window.

Timing:
- All outputs except the counters and FSM state are combinational from the current inputs and state. There is zero-cycle latency from a hazard to its hold.

Test Plan:
- fwd_en=1, exe_mem_read=1, exe_wb_en=1, exe_dest=5, id_src1=5, id_valid=1 for 1 cycle -> hold_pc_ifid=1, bubble_id=1, flush_ifid=0, stall_count 0→1. Same stimulus with id_src1=0 -> all 0.
- fwd_en=0, mem_wb_en=1, mem_dest=7, id_src2=7, id_two_src=1 -> hold=1, bubble=1. With id_two_src=0 -> no hazard.
- mem_req held high with MEM_WAIT_CYCLES=4 -> mem_stall high exactly 4 cycles, mem_done pulses in the 5th cycle, and the FSM returns to IDLE. A second request gives its next stall window starting in the 6th cycle.
- branch_taken=1 asserted during a stall window -> flush_ifid=0 until the window ends, then flush_ifid=1 and bubble_id=1 in the DONE cycle; flush_count increments once.
- branch_taken=1 together with a load-use hazard -> hold_pc_ifid=0, flush_ifid=1, bubble_id=1.
- reset=0 on the 2nd cycle of a window -> mem_stall=0 immediately, counters cleared. Force stall_count to all-ones with a continuous hazard -> stall_count holds at 0xFFFF.
